pixie_fb_arbiter: RTL

PIXIE_FB_ARBITER -- requirements
Module: pixie_fb_arbiter

---
 rtl/pixie_fb_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pixie_fb_arbiter.sv
// ---------------------------------------------------------------------------
// pixie_fb_arbiter
//
// Purpose:
//   Arbitrates three writers onto a single registered frame-buffer write
//   port. Priority per clk cycle is: Pixie front end (display DMA) > host
//   (loader/OSD) > full-buffer clear engine. The front end is never stalled;
//   the host holds a level request until acknowledged; the clear engine
//   fills every address 0..2^ADDR_W-1 with a latched value, advancing only
//   on cycles it actually wins.
//
// Ports:
//   clk, reset                     system clock, async active-high reset
//   clk_enable                     CPU clock-enable qualifying fe_wr_en
//   fe_wr_en/fe_addr/fe_data       front-end write
//   host_req/host_addr/host_data   host write request (level, held to ack)
//   host_ack                       one-cycle ack, coincident with host write
//   clear_start/clear_value        start (or restart) a full-buffer fill
//   clear_busy/clear_done          fill in progress / completion pulse
//   fb_wr_en/fb_addr/fb_data       registered frame-buffer write port
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module pixie_fb_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic              fe_wr_en,
    input  logic [ADDR_W-1:0] fe_addr,
    input  logic [DATA_W-1:0] fe_data,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ack,
    input  logic              clear_start,
    input  logic [DATA_W-1:0] clear_value,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              fb_wr_en,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_data
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clearAddr_q, clearAddr_d;
    logic [DATA_W-1:0] clearValue_q, clearValue_d;
    logic              clearDone_q, clearDone_d;
    logic              hostAck_q, hostAck_d;
    logic              fbWrEn_q, fbWrEn_d;
    logic [ADDR_W-1:0] fbAddr_q, fbAddr_d;
    logic [DATA_W-1:0] fbData_q, fbData_d;

    logic feGrant;
    logic hostGrant;
    logic clearGrant;

    // Fixed-priority grant. The host is blocked in the cycle its ack is
    // showing so a still-high request is not served twice. A clear_start
    // cycle grants nothing to the clear engine: the pass is being
    // (re)armed, so the first write of the new pass is address 0 with the
    // new value and no stale write of the old pass slips out.
    always_comb begin
        feGrant    = fe_wr_en & clk_enable;
        hostGrant  = ~feGrant & host_req & ~hostAck_q;
        clearGrant = ~feGrant & ~hostGrant & (state_q == CLEAR) & ~clear_start;
    end

    // Clear FSM next-state. clear_start always wins, including in the cycle
    // that would have been the final write, so an aborted pass never
    // reports completion.
    always_comb begin
        state_d      = state_q;
        clearAddr_d  = clearAddr_q;
        clearValue_d = clearValue_q;
        clearDone_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d      = CLEAR;
                    clearAddr_d  = '0;
                    clearValue_d = clear_value;
                end
            end
            CLEAR: begin
                if (clear_start) begin
                    clearAddr_d  = '0;
                    clearValue_d = clear_value;
                end else if (clearGrant) begin
                    if (clearAddr_q == LAST_ADDR) begin
                        state_d     = IDLE;
                        clearAddr_d = '0;
                        clearDone_d = 1'b1;
                    end else begin
                        clearAddr_d = clearAddr_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write-port mux. Address and data hold their last values on idle
    // cycles; only fb_wr_en drops.
    always_comb begin
        fbWrEn_d  = feGrant | hostGrant | clearGrant;
        fbAddr_d  = fbAddr_q;
        fbData_d  = fbData_q;
        hostAck_d = hostGrant;
        if (feGrant) begin
            fbAddr_d = fe_addr;
            fbData_d = fe_data;
        end else if (hostGrant) begin
            fbAddr_d = host_addr;
            fbData_d = host_data;
        end else if (clearGrant) begin
            fbAddr_d = clearAddr_q;
            fbData_d = clearValue_q;
        end
    end

    // All state and outputs are registered and cleared asynchronously, so
    // a pending host request or clear pass is simply forgotten on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            clearAddr_q  <= '0;
            clearValue_q <= '0;
            clearDone_q  <= 1'b0;
            hostAck_q    <= 1'b0;
            fbWrEn_q     <= 1'b0;
            fbAddr_q     <= '0;
            fbData_q     <= '0;
        end else begin
            state_q      <= state_d;
            clearAddr_q  <= clearAddr_d;
            clearValue_q <= clearValue_d;
            clearDone_q  <= clearDone_d;
            hostAck_q    <= hostAck_d;
            fbWrEn_q     <= fbWrEn_d;
            fbAddr_q     <= fbAddr_d;
            fbData_q     <= fbData_d;
        end
    end

    assign host_ack   = hostAck_q;
    assign clear_busy = (state_q == CLEAR);
    assign clear_done = clearDone_q;
    assign fb_wr_en   = fbWrEn_q;
    assign fb_addr    = fbAddr_q;
    assign fb_data    = fbData_q;

endmodule
